mem_access_stage: RTL and testbench

Pipeline MEM stage of the 8-bit core, sitting between the EX/MEM boundary and the data memory. It captures one EX-stage transaction per valid/ready handshake and drives the data memory's address, write data and read/write strobes from registered state for exactly one cycle. It then registers the load data, or passes the ALU result through, into a MEM/WB output register with its own valid/ready handshake. It also range-checks addresses against the data-memory depth and keeps saturating load, store and fault counters.

---
 rtl/mem_access_pkg.sv | 15 +
 rtl/mem_access_if.sv | 46 ++++
 rtl/mem_access_stage_sat_counter8.sv | 22 ++
 rtl/mem_access_stage.sv | 114 +++++++++++
 tb/tb_mem_access_stage.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/mem_access_pkg.sv
// Shared types and default sizing for the MEM pipeline stage of the 8-bit core.
package mem_access_pkg;
    localparam int DATA_W_DEF    = 8;
    localparam int ADDR_W_DEF    = 8;
    localparam int REG_W_DEF     = 3;
    localparam int MEM_DEPTH_DEF = 10;

    localparam logic [7:0] SAT_MAX = 8'hFF;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;
endpackage

// File: rtl/mem_access_if.sv
// EX/MEM input, data-memory and MEM/WB output signals of the MEM stage, bundled.
interface mem_access_if #(
    parameter int DATA_W = mem_access_pkg::DATA_W_DEF,
    parameter int ADDR_W = mem_access_pkg::ADDR_W_DEF,
    parameter int REG_W  = mem_access_pkg::REG_W_DEF
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_alu_result;
    logic [DATA_W-1:0] in_store_data;
    logic              in_mem_read;
    logic              in_mem_write;
    logic              in_reg_write;
    logic [REG_W-1:0]  in_rd;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_write_data;
    logic              mem_read;
    logic              mem_write;
    logic [DATA_W-1:0] mem_read_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_result;
    logic [REG_W-1:0]  out_rd;
    logic              out_reg_write;
    logic              out_fault;
    logic [7:0]        load_count;
    logic [7:0]        store_count;
    logic [7:0]        fault_count;

    modport slave (
        input  flush, in_valid, in_alu_result, in_store_data, in_mem_read,
               in_mem_write, in_reg_write, in_rd, mem_read_data, out_ready,
        output in_ready, mem_address, mem_write_data, mem_read, mem_write,
               out_valid, out_result, out_rd, out_reg_write, out_fault,
               load_count, store_count, fault_count
    );

    modport master (
        output flush, in_valid, in_alu_result, in_store_data, in_mem_read,
               in_mem_write, in_reg_write, in_rd, mem_read_data, out_ready,
        input  in_ready, mem_address, mem_write_data, mem_read, mem_write,
               out_valid, out_result, out_rd, out_reg_write, out_fault,
               load_count, store_count, fault_count
    );
endinterface

// File: rtl/mem_access_stage_sat_counter8.sv
// 8-bit event counter that sticks at 255 instead of wrapping.
module sat_counter8
    import mem_access_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       en_i,
    output logic [7:0] count_o
);
    logic [7:0] count_q;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (en_i && count_q != SAT_MAX) begin
            count_q <= count_q + 8'd1;
        end
    end

    assign count_o = count_q;
endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: one-cycle data-memory access from registered state, then a held MEM/WB entry.
module mem_access_stage
    import mem_access_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int REG_W     = REG_W_DEF,
    parameter int MEM_DEPTH = MEM_DEPTH_DEF
) (
    input  logic       clk,
    input  logic       reset,
    mem_access_if.slave bus
);
    localparam logic [DATA_W:0] DEPTH_L = (DATA_W + 1)'(MEM_DEPTH);

    state_t            state_q;
    logic [DATA_W-1:0] alu_q;
    logic [DATA_W-1:0] store_q;
    logic [REG_W-1:0]  rd_q;
    logic              rd_en_q;
    logic              wr_en_q;
    logic              reg_write_q;
    logic [DATA_W-1:0] result_q;
    logic [REG_W-1:0]  out_rd_q;
    logic              out_reg_write_q;
    logic              out_fault_q;

    logic in_access;
    logic in_range;
    logic fault;

    // Non-memory ops are never range-checked; read+write together is always a fault.
    always_comb begin
        in_access = (state_q == ACCESS);
        in_range  = ({1'b0, alu_q} < DEPTH_L);
        fault     = (rd_en_q & wr_en_q) | ((rd_en_q | wr_en_q) & ~in_range);
    end

    assign bus.mem_read       = in_access & rd_en_q & ~fault;
    assign bus.mem_write      = in_access & wr_en_q & ~fault;
    assign bus.mem_address    = in_access ? ADDR_W'(alu_q) : '0;
    assign bus.mem_write_data = in_access ? store_q : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            alu_q           <= '0;
            store_q         <= '0;
            rd_q            <= '0;
            rd_en_q         <= 1'b0;
            wr_en_q         <= 1'b0;
            reg_write_q     <= 1'b0;
            result_q        <= '0;
            out_rd_q        <= '0;
            out_reg_write_q <= 1'b0;
            out_fault_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid && !bus.flush) begin
                        alu_q       <= bus.in_alu_result;
                        store_q     <= bus.in_store_data;
                        rd_q        <= bus.in_rd;
                        rd_en_q     <= bus.in_mem_read;
                        wr_en_q     <= bus.in_mem_write;
                        reg_write_q <= bus.in_reg_write;
                        state_q     <= ACCESS;
                    end
                end
                ACCESS: begin
                    result_q        <= fault ? '0 : (rd_en_q ? bus.mem_read_data : alu_q);
                    out_rd_q        <= rd_q;
                    out_reg_write_q <= reg_write_q & ~fault;
                    out_fault_q     <= fault;
                    state_q         <= RESP;
                end
                RESP: begin
                    if (bus.flush || bus.out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready      = (state_q == IDLE);
    assign bus.out_valid     = (state_q == RESP);
    assign bus.out_result    = result_q;
    assign bus.out_rd        = out_rd_q;
    assign bus.out_reg_write = out_reg_write_q;
    assign bus.out_fault     = out_fault_q;

    sat_counter8 u_load_cnt (
        .clk     (clk),
        .reset   (reset),
        .en_i    (in_access & rd_en_q & ~fault),
        .count_o (bus.load_count)
    );

    sat_counter8 u_store_cnt (
        .clk     (clk),
        .reset   (reset),
        .en_i    (in_access & wr_en_q & ~fault),
        .count_o (bus.store_count)
    );

    sat_counter8 u_fault_cnt (
        .clk     (clk),
        .reset   (reset),
        .en_i    (in_access & fault),
        .count_o (bus.fault_count)
    );
endmodule

// File: tb/tb_mem_access_stage.sv
// Randomised and directed bench for mem_access_stage against a transaction-level model.
module tb_mem_access_stage;
    logic clk;
    logic reset;

    mem_access_if bus ();

    mem_access_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory seen by the DUT
    logic [7:0] dmem [256];
    always_comb bus.mem_read_data = dmem[bus.mem_address];
    always @(posedge clk) begin
        if (bus.mem_write) dmem[bus.mem_address] <= bus.mem_write_data;
    end

    // Reference model state
    logic [7:0] ref_mem [256];
    int exp_load, exp_store, exp_fault_cnt;
    int n_checks, n_bad;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v < 255) ? v + 1 : 255;
    endfunction

    // Called at #1 after a posedge with the DUT in IDLE; returns the same way.
    task automatic run_op(input logic r, input logic w, input logic [7:0] a, input logic [7:0] d,
                          input logic [2:0] rdi, input logic rw, input int stall, input logic fl);
        logic       e_fault;
        logic [7:0] e_res;
        e_fault = (r && w) || ((r || w) && a >= 8'd10);
        e_res   = e_fault ? 8'h00 : (r ? ref_mem[a] : a);
        if (!e_fault && w) ref_mem[a] = d;
        if (!e_fault && r) exp_load = sat_inc(exp_load);
        if (!e_fault && w) exp_store = sat_inc(exp_store);
        if (e_fault) exp_fault_cnt = sat_inc(exp_fault_cnt);

        bus.in_valid = 1'b1; bus.in_mem_read = r; bus.in_mem_write = w;
        bus.in_alu_result = a; bus.in_store_data = d; bus.in_rd = rdi;
        bus.in_reg_write = rw; bus.out_ready = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("acc_rd_strobe", bus.mem_read, r && !e_fault);
        check("acc_wr_strobe", bus.mem_write, w && !e_fault);
        check("acc_addr", bus.mem_address, a);
        check("acc_wdata", bus.mem_write_data, d);
        check("acc_in_ready", bus.in_ready, 0);
        check("acc_out_valid", bus.out_valid, 0);

        @(posedge clk); #1;
        check("resp_valid", bus.out_valid, 1);
        check("resp_result", bus.out_result, e_res);
        check("resp_fault", bus.out_fault, e_fault);
        check("resp_regwr", bus.out_reg_write, rw && !e_fault);
        check("resp_rd", bus.out_rd, rdi);
        check("load_count", bus.load_count, exp_load);
        check("store_count", bus.store_count, exp_store);
        check("fault_count", bus.fault_count, exp_fault_cnt);
        check("resp_no_strobe", bus.mem_read | bus.mem_write, 0);

        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            check("stall_valid", bus.out_valid, 1);
            check("stall_result", bus.out_result, e_res);
            check("stall_rd", bus.out_rd, rdi);
            check("stall_in_ready", bus.in_ready, 0);
            check("stall_no_strobe", bus.mem_read | bus.mem_write, 0);
        end

        if (fl) begin
            bus.flush = 1'b1;
            @(posedge clk); #1;
            bus.flush = 1'b0;
            check("flush_valid", bus.out_valid, 0);
            check("flush_in_ready", bus.in_ready, 1);
        end else begin
            bus.out_ready = 1'b1;
            @(posedge clk); #1;
            bus.out_ready = 1'b0;
            check("done_valid", bus.out_valid, 0);
            check("done_in_ready", bus.in_ready, 1);
        end
    endtask

    initial begin
        n_checks = 0; n_bad = 0;
        exp_load = 0; exp_store = 0; exp_fault_cnt = 0;
        reset = 1'b1;
        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_alu_result = '0; bus.in_store_data = '0;
        bus.in_mem_read = 1'b0; bus.in_mem_write = 1'b0; bus.in_reg_write = 1'b0;
        bus.in_rd = '0; bus.out_ready = 1'b0;
        #22 reset = 1'b0;
        @(posedge clk); #1;

        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_strobes", bus.mem_read | bus.mem_write, 0);
        check("rst_result", bus.out_result, 0);
        check("rst_counts", {bus.load_count, bus.store_count, bus.fault_count}, 0);

        // Preload every legal word so later loads have known data
        for (int i = 0; i < 10; i++) run_op(0, 1, 8'(i), 8'($urandom), 3'd0, 0, 0, 0);

        // Store then load at address 3
        run_op(0, 1, 8'd3, 8'h5A, 3'd1, 0, 0, 0);
        run_op(1, 0, 8'd3, 8'h00, 3'd2, 1, 0, 0);
        check("load_5a", ref_mem[3], 8'h5A);
        // Out-of-range load at MEM_DEPTH
        run_op(1, 0, 8'd10, 8'h00, 3'd3, 1, 0, 0);
        // Non-memory op
        run_op(0, 0, 8'hC3, 8'h11, 3'd5, 1, 0, 0);
        // Backpressure for 5 cycles
        run_op(1, 0, 8'd7, 8'h00, 3'd6, 1, 5, 0);

        // flush in IDLE blocks capture
        bus.flush = 1'b1; bus.in_valid = 1'b1; bus.in_mem_write = 1'b1; bus.in_alu_result = 8'd2;
        #1 check("idle_flush_ready", bus.in_ready, 1);
        @(posedge clk); #1;
        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_mem_write = 1'b0;
        check("idle_flush_no_acc", bus.in_ready, 1);
        check("idle_flush_no_strobe", bus.mem_write, 0);

        // Randomised traffic
        for (int n = 0; n < 80; n++) begin
            int kind;
            kind = $urandom_range(0, 3);
            run_op(kind == 0 || kind == 3, kind == 1 || kind == 3, 8'($urandom_range(0, 13)),
                   8'($urandom), 3'($urandom), 1'($urandom), $urandom_range(0, 2),
                   $urandom_range(0, 7) == 0);
        end

        // Reset during ACCESS of a store
        bus.in_valid = 1'b1; bus.in_mem_write = 1'b1; bus.in_mem_read = 1'b0;
        bus.in_alu_result = 8'd4; bus.in_store_data = ~ref_mem[4];
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.in_mem_write = 1'b0;
        check("pre_rst_wr", bus.mem_write, 1);
        #2 reset = 1'b1;
        #1;
        check("arst_wr", bus.mem_write, 0);
        check("arst_rd", bus.mem_read, 0);
        check("arst_valid", bus.out_valid, 0);
        check("arst_in_ready", bus.in_ready, 1);
        check("arst_outs", {bus.out_result, bus.out_fault, bus.out_reg_write}, 0);
        check("arst_counts", {bus.load_count, bus.store_count, bus.fault_count}, 0);
        @(negedge clk); reset = 1'b0;
        exp_load = 0; exp_store = 0; exp_fault_cnt = 0;
        @(posedge clk); #1;
        run_op(1, 0, 8'd4, 8'h00, 3'd4, 1, 0, 0);

        // Load counter saturation
        for (int n = 0; n < 260; n++) run_op(1, 0, 8'($urandom_range(0, 9)), 8'h00, 3'd1, 1, 0, 0);
        check("load_sat", bus.load_count, 255);
        run_op(1, 0, 8'd9, 8'h00, 3'd7, 1, 1, 1);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end
endmodule
